// File: rtl/adsr_envelope.sv
// adsr_envelope
// Turns a note gate into an unsigned 16-bit amplitude that walks through
// attack, decay, sustain and release. The level moves only on a prescaled
// update tick. Gate edges are acted on every clock.
module adsr_envelope #(
  parameter int unsigned PRESCALE = 50
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_gate,
  input  logic [15:0] i_attack_inc,
  input  logic [15:0] i_decay_dec,
  input  logic [15:0] i_sustain,
  input  logic [15:0] i_release_dec,
  output logic [15:0] o_amp,
  output logic [2:0]  o_state,
  output logic        o_active
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        gate_q, gate_d;
  state_t      state_q, state_d;
  logic [15:0] level_q, level_d;
  logic        active_q, active_d;

  logic        tick;
  logic        gate_rise;
  logic        gate_fall;
  logic [16:0] attack_sum;
  logic [16:0] decay_diff;
  logic [16:0] release_diff;

  // Free-running prescaler; the tick marks the last count before it wraps.
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
  end

  // Next state and level: gate events first, then tick-driven arithmetic.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    gate_d       = i_gate;
    gate_rise    = i_gate & ~gate_q;
    gate_fall    = ~i_gate & ((state_q == ATTACK) || (state_q == DECAY) ||
                              (state_q == SUSTAIN));
    attack_sum   = {1'b0, level_q} + {1'b0, i_attack_inc};
    decay_diff   = {1'b0, level_q} - {1'b0, i_decay_dec};
    release_diff = {1'b0, level_q} - {1'b0, i_release_dec};

    if (gate_rise) begin
      state_d = ATTACK;
    end else if (gate_fall) begin
      state_d = RELEASE;
    end else if (tick) begin
      case (state_q)
        IDLE: begin
          level_d = 16'd0;
        end
        ATTACK: begin
          if ((i_attack_inc == 16'd0) || (attack_sum >= 17'h0FFFF)) begin
            level_d = 16'hFFFF;
            state_d = DECAY;
          end else begin
            level_d = attack_sum[15:0];
          end
        end
        DECAY: begin
          if ((i_decay_dec == 16'd0) ||
              ($signed(decay_diff) <= $signed({1'b0, i_sustain}))) begin
            level_d = i_sustain;
            state_d = SUSTAIN;
          end else begin
            level_d = decay_diff[15:0];
          end
        end
        SUSTAIN: begin
          level_d = i_sustain;
        end
        RELEASE: begin
          if ((i_release_dec == 16'd0) || ($signed(release_diff) <= 17'sd0)) begin
            level_d = 16'd0;
            state_d = IDLE;
          end else begin
            level_d = release_diff[15:0];
          end
        end
        default: begin
          level_d = 16'd0;
          state_d = IDLE;
        end
      endcase
    end

    active_d = (state_d != IDLE);
  end

  // State, level, gate history and prescaler registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q    <= 16'd0;
      gate_q   <= 1'b0;
      state_q  <= IDLE;
      level_q  <= 16'd0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      gate_q   <= gate_d;
      state_q  <= state_d;
      level_q  <= level_d;
      active_q <= active_d;
    end
  end

  assign o_amp    = level_q;
  assign o_state  = state_q;
  assign o_active = active_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope
// Directed checks of the ADSR envelope with a 4-clock update tick.
module tb_adsr_envelope;

  logic        clk;
  logic        rst;
  logic        gate;
  logic [15:0] attack_inc;
  logic [15:0] decay_dec;
  logic [15:0] sustain;
  logic [15:0] release_dec;
  logic [15:0] amp;
  logic [2:0]  state;
  logic        active;

  int testsRun;
  int testsFailed;
  int phase;

  adsr_envelope #(.PRESCALE(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_gate       (gate),
    .i_attack_inc (attack_inc),
    .i_decay_dec  (decay_dec),
    .i_sustain    (sustain),
    .i_release_dec(release_dec),
    .o_amp        (amp),
    .o_state      (state),
    .o_active     (active)
  );

  // 10 ns clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count it.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive the gate and the rate/sustain inputs together.
  task automatic applyStimulus(input logic g, input logic [15:0] atk,
                               input logic [15:0] dec, input logic [15:0] sus,
                               input logic [15:0] rel);
    gate        = g;
    attack_inc  = atk;
    decay_dec   = dec;
    sustain     = sus;
    release_dec = rel;
  endtask

  // Advance one clock; the bench tracks the prescaler phase on its own.
  task automatic stepClock();
    @(posedge clk);
    if (rst) phase = 0;
    else     phase = (phase + 1) % 4;
    #1;
  endtask

  // Advance up to and including the edge that ends the next tick cycle.
  task automatic runToTick();
    bit wasTick;
    int guard;
    guard = 0;
    do begin
      wasTick = (phase == 3);
      stepClock();
      guard++;
    end while (!wasTick && guard < 8);
  endtask

  // Check level, state and active flag in one go.
  task automatic checkEnv(input string tag, input logic [15:0] expAmp,
                          input logic [2:0] expState);
    checkOutput({tag, ".amp"}, 32'(amp), 32'(expAmp));
    checkOutput({tag, ".state"}, 32'(state), 32'(expState));
    checkOutput({tag, ".active"}, 32'(active), 32'(expState != 3'd0));
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    phase       = 0;
    rst         = 1'b1;
    applyStimulus(1'b1, 16'h4000, 16'h1000, 16'hE000, 16'h8000);

    // Reset held three clocks with the gate high.
    for (int i = 0; i < 3; i++) begin
      stepClock();
      checkOutput("reset.amp", 32'(amp), 32'h0);
      checkOutput("reset.state", 32'(state), 32'h0);
    end
    rst = 1'b0;
    stepClock();
    checkEnv("post_reset", 16'h0000, 3'd1);

    // Attack in four ticks, then decay into sustain.
    runToTick(); checkEnv("attack1", 16'h4000, 3'd1);
    runToTick(); checkEnv("attack2", 16'h8000, 3'd1);
    runToTick(); checkEnv("attack3", 16'hC000, 3'd1);
    runToTick(); checkEnv("attack4", 16'hFFFF, 3'd2);
    runToTick(); checkEnv("decay1", 16'hEFFF, 3'd2);
    runToTick(); checkEnv("decay2", 16'hE000, 3'd3);
    sustain = 16'hA000;
    runToTick(); checkEnv("sustain_track", 16'hA000, 3'd3);
    sustain = 16'hE000;
    runToTick(); checkEnv("sustain_back", 16'hE000, 3'd3);

    // Release to idle.
    gate = 1'b0;
    stepClock(); checkEnv("release_enter", 16'hE000, 3'd4);
    runToTick(); checkEnv("release1", 16'h6000, 3'd4);
    runToTick(); checkEnv("release2", 16'h0000, 3'd0);

    // Second envelope up to sustain, release once, then retrigger.
    gate = 1'b1;
    stepClock(); checkEnv("second_attack", 16'h0000, 3'd1);
    for (int i = 0; i < 6; i++) runToTick();
    checkEnv("second_sustain", 16'hE000, 3'd3);
    gate = 1'b0;
    stepClock();
    runToTick(); checkEnv("pre_retrig", 16'h6000, 3'd4);
    gate = 1'b1;
    stepClock(); checkEnv("retrig", 16'h6000, 3'd1);
    runToTick(); checkEnv("retrig1", 16'hA000, 3'd1);
    runToTick(); checkEnv("retrig2", 16'hE000, 3'd1);
    runToTick(); checkEnv("retrig3", 16'hFFFF, 3'd2);

    // Zero rates: each stage completes on its first tick.
    applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h8000, 16'h0000);
    stepClock(); checkEnv("zero_rel_enter", 16'hFFFF, 3'd4);
    runToTick(); checkEnv("zero_rel", 16'h0000, 3'd0);
    while (phase != 3) stepClock();
    gate = 1'b1;
    stepClock(); checkEnv("collision", 16'h0000, 3'd1);
    runToTick(); checkEnv("zero_attack", 16'hFFFF, 3'd2);
    runToTick(); checkEnv("zero_decay", 16'h8000, 3'd3);
    gate = 1'b0;
    stepClock(); checkEnv("zero_fall", 16'h8000, 3'd4);
    runToTick(); checkEnv("zero_release", 16'h0000, 3'd0);

    // Reset in the middle of an attack.
    applyStimulus(1'b1, 16'h4000, 16'h1000, 16'hE000, 16'h8000);
    stepClock();
    runToTick(); checkEnv("mid_attack", 16'h4000, 3'd1);
    rst = 1'b1;
    stepClock(); checkEnv("mid_reset", 16'h0000, 3'd0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
